// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file: round-robin between ALU and load unit,
// one registered write per cycle, plus a pending-write scoreboard for WAW stalls.
module regfile_wb_arbiter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  output logic            iss_ready,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [31:0]     busy
);

  logic            last_mem_q, last_mem_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic [31:0]     busy_q, busy_d;

  logic            alu_xfer, mem_xfer, wb_fire;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  // On contention the side that did not win last time gets the slot.
  always_comb begin
    alu_ready = !reset && alu_valid && (!mem_valid || last_mem_q);
    mem_ready = !reset && mem_valid && (!alu_valid || !last_mem_q);
    iss_ready = !busy_q[iss_rd] || (iss_rd == 5'd0);
  end

  always_comb begin
    alu_xfer = alu_valid && alu_ready;
    mem_xfer = mem_valid && mem_ready;
    wb_fire  = alu_xfer || mem_xfer;
    wb_rd    = alu_xfer ? alu_rd : mem_rd;
    wb_data  = alu_xfer ? alu_data : mem_data;
  end

  always_comb begin
    last_mem_d = wb_fire ? mem_xfer : last_mem_q;
    rf_we_d    = wb_fire && (wb_rd != 5'd0);
    rf_waddr_d = rf_we_d ? wb_rd : rf_waddr_q;
    rf_wdata_d = rf_we_d ? wb_data : rf_wdata_q;
    busy_d     = busy_q;
    if (rf_we_d) busy_d[wb_rd] = 1'b0;
    // Issue applied after the clear so a same-cycle set on that register wins.
    if (iss_valid && iss_ready && (iss_rd != 5'd0)) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_mem_q <= 1'b1;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= '0;
      busy_q     <= 32'd0;
    end else begin
      last_mem_q <= last_mem_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration, write latency, scoreboard, x0, async reset.
module tb_regfile_wb_arbiter;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_valid, mem_valid, iss_valid;
  logic [4:0]      alu_rd, mem_rd, iss_rd;
  logic [XLEN-1:0] alu_data, mem_data;
  logic            alu_ready, mem_ready, iss_ready;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [31:0]     busy;

  int errors = 0;
  int checks = 0;

  regfile_wb_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = 5'd0; mem_data = '0;
    iss_valid = 1'b0; iss_rd = 5'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    #2 reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    alu_valid = 1'b1; mem_valid = 1'b1; alu_rd = 5'd3; mem_rd = 5'd4;
    iss_rd = 5'd12;
    step();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
    checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_rf_waddr: got %0d want 0", rf_waddr); end
    checks++; if (rf_wdata !== 64'd0) begin errors++; $display("FAIL reset_rf_wdata: got %h want 0", rf_wdata); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL reset_busy: got %h want 0", busy); end
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready: got %b want 0", alu_ready); end
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_ready: got %b want 0", mem_ready); end
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL reset_iss_ready: got %b want 1", iss_ready); end
    idle_inputs();
    #2 reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_alu_ready: got %b want 1", alu_ready); end
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL single_mem_ready: got %b want 0", mem_ready); end
    step();
    idle_inputs();
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL single_we_n1: got %b want 1", rf_we); end
    checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL single_waddr: got %0d want 5", rf_waddr); end
    checks++; if (rf_wdata !== 64'h1234) begin errors++; $display("FAIL single_wdata: got %h want 1234", rf_wdata); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL single_busy_unreserved: got %h want 0", busy); end
    step();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_we_n2: got %b want 0", rf_we); end
    checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL single_waddr_hold: got %0d want 5", rf_waddr); end
    checks++; if (rf_wdata !== 64'h1234) begin errors++; $display("FAIL single_wdata_hold: got %h want 1234", rf_wdata); end
  endtask

  task automatic test_contention();
    logic [4:0] exp_addr [3];
    logic       exp_alu  [3];
    exp_addr[0] = 5'd1; exp_addr[1] = 5'd2; exp_addr[2] = 5'd1;
    exp_alu[0]  = 1'b1; exp_alu[1]  = 1'b0; exp_alu[2]  = 1'b1;
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'hA1;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 64'hB2;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (alu_ready !== exp_alu[i] || mem_ready !== !exp_alu[i]) begin
        errors++; $display("FAIL contention_grant[%0d]: got alu=%b mem=%b want alu=%b", i, alu_ready, mem_ready, exp_alu[i]);
      end
      step();
      if (i == 2) idle_inputs();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== exp_addr[i]) begin
        errors++; $display("FAIL contention_waddr[%0d]: got we=%b addr=%0d want we=1 addr=%0d", i, rf_we, rf_waddr, exp_addr[i]);
      end
      checks++; if (rf_wdata !== (exp_alu[i] ? 64'hA1 : 64'hB2)) begin
        errors++; $display("FAIL contention_wdata[%0d]: got %h", i, rf_wdata);
      end
    end
    step();
  endtask

  task automatic test_scoreboard();
    do_reset();
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sb_iss_ready_free: got %b want 1", iss_ready); end
    step();
    iss_valid = 1'b0;
    #1;
    checks++; if (busy !== 32'h0000_0080) begin errors++; $display("FAIL sb_busy_set: got %h want 00000080", busy); end
    checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL sb_iss_ready_busy: got %b want 0", iss_ready); end
    step();
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 64'hDEAD_BEEF;
    #1;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL sb_mem_ready: got %b want 1", mem_ready); end
    step();
    idle_inputs();
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL sb_busy_clear: got %h want 0", busy); end
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 64'hDEAD_BEEF) begin
      errors++; $display("FAIL sb_mem_write: got we=%b addr=%0d data=%h want 1/7/deadbeef", rf_we, rf_waddr, rf_wdata);
    end
    step();
  endtask

  task automatic test_collision();
    do_reset();
    iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    checks++; if (busy !== 32'h0000_0200) begin errors++; $display("FAIL col_busy_set: got %h want 00000200", busy); end
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99;
    #1;
    checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL col_iss_blocked: got %b want 0", iss_ready); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL col_alu_ready: got %b want 1", alu_ready); end
    step();
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL col_busy_cleared: got %h want 0", busy); end
    alu_data = 64'h9A;
    #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL col_iss_accept: got %b want 1", iss_ready); end
    step();
    idle_inputs();
    checks++; if (busy !== 32'h0000_0200) begin errors++; $display("FAIL col_set_wins: got %h want 00000200", busy); end
    checks++; if (rf_we !== 1'b1 || rf_wdata !== 64'h9A) begin
      errors++; $display("FAIL col_write: got we=%b data=%h want 1/9a", rf_we, rf_wdata);
    end
    step();
  endtask

  task automatic test_x0();
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'h55;
    iss_valid = 1'b1; iss_rd = 5'd0;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL x0_alu_ready: got %b want 1", alu_ready); end
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL x0_iss_ready: got %b want 1", iss_ready); end
    step();
    idle_inputs();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_rf_we: got %b want 0", rf_we); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL x0_busy: got %h want 0", busy); end
    // Pointer moved to ALU on the x0 grant, so MEM must win the next contention.
    alu_valid = 1'b1; alu_rd = 5'd3; mem_valid = 1'b1; mem_rd = 5'd4;
    #1;
    checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
      errors++; $display("FAIL x0_pointer: got alu=%b mem=%b want alu=0 mem=1", alu_ready, mem_ready);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    iss_valid = 1'b1; iss_rd = 5'd4;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h33;
    step();
    iss_valid = 1'b0;
    alu_rd = 5'd6; alu_data = 64'h66;
    #1;
    checks++; if (busy !== 32'h0000_0010 || rf_we !== 1'b1) begin
      errors++; $display("FAIL ar_pre: got busy=%h we=%b want 00000010/1", busy, rf_we);
    end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL ar_accept: got %b want 1", alu_ready); end
    reset = 1'b1;
    #1;
    checks++; if (rf_we !== 1'b0 || busy !== 32'd0 || rf_waddr !== 5'd0) begin
      errors++; $display("FAIL ar_immediate: got we=%b busy=%h addr=%0d want 0/0/0", rf_we, busy, rf_waddr);
    end
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL ar_ready_low: got %b want 0", alu_ready); end
    #1 reset = 1'b0;
    idle_inputs();
    step();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL ar_no_write1: got %b want 0", rf_we); end
    step();
    checks++; if (rf_we !== 1'b0 || busy !== 32'd0) begin
      errors++; $display("FAIL ar_no_write2: got we=%b busy=%h want 0/0", rf_we, busy);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_scoreboard();
    test_collision();
    test_x0();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 64, the write-back data width in bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  the reset, asynchronous and active-high.
REQ-004 SHALL have port alu_valid  input  1  ALU write-back request.
REQ-005 SHALL have port alu_rd  input  5  ALU destination register.
REQ-006 SHALL have port alu_data  input  XLEN  ALU result.
REQ-007 SHALL have port alu_ready  output  1  ALU request accepted this cycle.
REQ-008 SHALL have port mem_valid  input  1  load-unit write-back request.
REQ-009 SHALL have port mem_rd  input  5  load destination register.
REQ-010 SHALL have port mem_data  input  XLEN  load result.
REQ-011 SHALL have port mem_ready  output  1  load request accepted this cycle.
REQ-012 SHALL have port iss_valid  input  1  issue stage reserving a destination register.
REQ-013 SHALL have port iss_rd  input  5  register being reserved.
REQ-014 SHALL have port iss_ready  output  1  reservation accepted this cycle.
REQ-015 SHALL have port rf_we  output  1  register-file write enable, registered.
REQ-016 SHALL have port rf_waddr  output  5  register-file write address, registered.
REQ-017 SHALL have port rf_wdata  output  XLEN  register-file write data, registered.
REQ-018 SHALL have port busy  output  32  scoreboard: bit n set = xn has a pending write; registered.

Function
REQ-019 SHALL accept at most one write-back request per cycle; a transfer occurs when valid and ready are both high in the same cycle.
REQ-020 SHALL drive alu_ready/mem_ready combinationally from the valids and the round-robin pointer, and never high for both in one cycle.
REQ-021 SHALL grant the sole requester when only one valid is high.
REQ-022 SHALL, when both valids are high, grant the requester not granted on the most recent grant; pointer resets to "last = MEM" so ALU wins the first contention.
REQ-023 SHALL update the round-robin pointer on every grant, contended or not.
REQ-024 SHALL, for a transfer accepted in cycle N with rd != 0, assert rf_we=1 with rf_waddr=rd and rf_wdata=data during cycle N+1 (latency 1).
REQ-025 SHALL drive rf_we=0 in cycle N+1 when no transfer occurred in cycle N; rf_waddr/rf_wdata hold their last values.
REQ-026 SHALL accept a transfer with rd=0 (ready asserted normally) but produce rf_we=0 and no scoreboard change.
REQ-027 SHALL clear busy[rd] at the same edge that registers the write (visible in cycle N+1).
REQ-028 SHALL drive iss_ready = iss_valid-independent !busy[iss_rd] OR iss_rd==0 (WAW stall on a busy register).
REQ-029 SHALL set busy[iss_rd] at the edge ending a cycle with iss_valid && iss_ready && iss_rd != 0.
REQ-030 SHALL, when set (issue) and clear (write-back) target the same register in one cycle, leave the bit set.
REQ-031 SHALL hold busy[0]=0 at all times.
REQ-032 SHALL not check that a write-back's rd is busy; an unreserved write-back writes normally and leaves busy unchanged.

Reset
REQ-033 SHALL, while reset=1, immediately force rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, pointer "last = MEM", independent of clk.
REQ-034 SHALL, when reset asserts mid-operation, discard any accepted-but-unwritten transfer (no rf_we pulse after reset).
REQ-035 SHALL drive alu_ready=mem_ready=0 while reset=1; iss_ready follows REQ-028 (busy=0).

Verification
REQ-036 Single: alu_valid, alu_rd=5, alu_data=0x1234 in cycle N -> alu_ready=1 in N; rf_we=1, rf_waddr=5, rf_wdata=0x1234 in N+1; rf_we=0 in N+2.
REQ-037 Contention: both valid for 3 cycles after reset (alu_rd=1, mem_rd=2) -> grants ALU, MEM, ALU; rf_waddr sequence 1,2,1.
REQ-038 Scoreboard: issue rd=7 in N -> busy[7]=1 in N+1, iss_ready=0 for rd=7; mem write-back rd=7 accepted in N+2 -> busy[7]=0 in N+3.
REQ-039 Collision: busy[9]=1, issue rd=9 blocked; same cycle alu write-back rd=9 accepted plus new issue rd=9 next cycle with write -> busy[9] stays 1.
REQ-040 x0: alu_rd=0, iss_rd=0 -> alu_ready=1, iss_ready=1, rf_we=0 next cycle, busy unchanged (0).
REQ-041 Async reset: transfer accepted, reset pulsed between clock edges -> rf_we=0 and busy=0 immediately; no write after release.
